axi_burst_master: RTL and testbench

//  AXI4 initiator that turns a single command (addr/len/size/dir) into one INCR write or read burst on
//  the team's AXI bus. It is the manager-side counterpart of the AXI slave memory. It sits between

---
 rtl/axi_pkg.sv | 42 ++++
 rtl/axi_beat_counter.sv | 30 +++
 rtl/axi_burst_master.sv | 213 +++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI burst master.
//   axi_resp_e   : AXI response codes, ordered so that a larger value is a worse outcome
//   mst_state_e  : burst master FSM states
//   AXI_4KB      : size of the AXI address page that a burst must not cross
//   crosses_4kb  : 1 when a burst of (len+1) beats of 2**size bytes starting at the
//                  given in-page offset runs past the end of the 4 KB page
//   resp_worst   : the numerically larger (worse) of two responses
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } mst_state_e;

    localparam int AXI_4KB = 4096;

    function automatic logic crosses_4kb(input logic [11:0] offset,
                                         input logic [7:0]  len,
                                         input logic [2:0]  size);
        logic [16:0] nbytes;   // largest burst is 256 beats << 7 = 32768 bytes
        logic [17:0] end_off;
        nbytes  = (17'(len) + 17'd1) << size;
        end_off = 18'(offset) + 18'(nbytes);
        return end_off > 18'(AXI_4KB);
    endfunction

    function automatic axi_resp_e resp_worst(input axi_resp_e a, input axi_resp_e b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the write-data and read-data phases of a burst.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : restart the count at zero (new command accepted)
//   inc      : one data beat handshaked this cycle
//   len      : burst length in AXLEN encoding (beats - 1)
//   beat     : index of the beat currently on the bus (9 bits so a 256-beat burst never wraps)
//   last     : the current beat is the final one of the burst
module axi_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    input  logic [7:0] len,
    output logic [8:0] beat,
    output logic       last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (inc) begin
            beat <= beat + 9'd1;
        end
    end

    assign last = (beat == {1'b0, len});

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 manager that turns one local command into a single INCR write or read burst.
// One transaction is in flight at a time; completion is a one-cycle done pulse with status.
//   ACLK, ARESET           : clock, asynchronous active-high reset
//   cmd_*                  : command handshake (write/read, start address, AXLEN, AXSIZE)
//   wd_valid/ready/data    : local write-data stream, passed straight onto the W channel
//   rd_valid/ready/data/last : local read-data stream, passed straight from the R channel
//   done, done_resp        : completion pulse and its AXI response code
//   AW*, W*, B*, AR*, R*   : AXI4 manager-side channel signals
// Illegal commands (beat size wider than the bus, or a burst crossing a 4 KB page) are
// accepted but produce no bus activity; they complete one cycle later with SLVERR.
// ADDR_WIDTH must be at least 12 so that the in-page offset is available.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    // local write-data stream
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    // local read-data stream
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    // write address channel
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // write response channel
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // read address channel
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // read data channel
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    mst_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    axi_resp_e             resp_acc;
    axi_resp_e             r_worst;
    logic                  done_q;
    axi_resp_e             done_resp_q;

    logic                  cmd_fire;
    logic                  cmd_illegal;
    logic                  w_fire;
    logic                  r_fire;
    logic                  b_fire;
    logic                  r_len_err;
    logic [8:0]            beat;
    logic                  beat_last;

    assign cmd_fire    = cmd_valid & cmd_ready;
    assign cmd_illegal = (cmd_size > MAX_SIZE) | crosses_4kb(cmd_addr[11:0], cmd_len, cmd_size);
    assign w_fire      = (state == ST_WDATA) & wd_valid & WREADY;
    assign r_fire      = (state == ST_RDATA) & RVALID & rd_ready;
    assign b_fire      = (state == ST_WRESP) & BVALID;
    assign r_worst     = resp_worst(resp_acc, axi_resp_e'(RRESP));
    // RLAST on any beat other than the one AXLEN announced is a protocol error.
    assign r_len_err   = (beat != {1'b0, len_q});

    axi_beat_counter u_beat (
        .clk   (ACLK),
        .rst   (ARESET),
        .clear (cmd_fire),
        .inc   (w_fire | r_fire),
        .len   (len_q),
        .beat  (beat),
        .last  (beat_last)
    );

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                // Illegal commands are consumed here and never leave IDLE.
                if (cmd_valid && !cmd_illegal) begin
                    state_nxt = cmd_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: if (AWREADY)             state_nxt = ST_WDATA;
            ST_WDATA: if (w_fire && beat_last) state_nxt = ST_WRESP;
            ST_WRESP: if (BVALID)              state_nxt = ST_IDLE;
            ST_RADDR: if (ARREADY)             state_nxt = ST_RDATA;
            ST_RDATA: if (r_fire && RLAST)     state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: every VALID depends only on state and local-side valids, never on a READY.
    always_comb begin
        cmd_ready = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        wd_ready  = 1'b0;
        BREADY    = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        unique case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_WADDR: AWVALID   = 1'b1;
            ST_WDATA: begin
                WVALID   = wd_valid;
                wd_ready = WREADY;
                WLAST    = beat_last;
            end
            ST_WRESP: BREADY    = 1'b1;
            ST_RADDR: ARVALID   = 1'b1;
            ST_RDATA: begin
                RREADY   = rd_ready;
                rd_valid = RVALID;
                rd_last  = RLAST;
            end
            default: ;
        endcase
    end

    // Command registers, response accumulation and completion pulse
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            resp_acc    <= RESP_OKAY;
            done_q      <= 1'b0;
            done_resp_q <= RESP_OKAY;
        end else begin
            done_q      <= 1'b0;
            done_resp_q <= RESP_OKAY;
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                size_q   <= cmd_size;
                resp_acc <= RESP_OKAY;
                if (cmd_illegal) begin
                    done_q      <= 1'b1;
                    done_resp_q <= RESP_SLVERR;
                end
            end
            if (b_fire) begin
                done_q      <= 1'b1;
                done_resp_q <= axi_resp_e'(BRESP);
            end
            if (r_fire) begin
                resp_acc <= r_worst;
                if (RLAST) begin
                    done_q      <= 1'b1;
                    done_resp_q <= r_len_err ? RESP_SLVERR : r_worst;
                end
            end
        end
    end

    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign WDATA     = wd_data;
    assign rd_data   = RDATA;

endmodule

// File: tb/tb_axi_burst_master.sv
`timescale 1ns/1ps
module tb_axi_burst_master;

    localparam int DW = 32;
    localparam int AW = 16;

    localparam int K_AW = 0;
    localparam int K_W  = 1;
    localparam int K_AR = 2;
    localparam int K_R  = 3;
    localparam int K_D  = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          done;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic          AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [1:0]    BRESP, RRESP;
    logic          BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t expq[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Address-phase summary: len, size, cycles VALID was high, and whether fields stayed stable.
    function automatic logic [31:0] addr_info(input logic [7:0] len, input logic [2:0] size,
                                              input int hold, input bit stable);
        return {11'd0, stable, hold[7:0], 1'b0, size, len};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b,
                           input string name);
        ev_t e;
        n_vec++;
        if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event a=%h b=%h, none expected", name, a, b);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d a=%h b=%h expected kind=%0d a=%h b=%h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // Monitor: observes every handshake on the falling edge and checks it against the queue.
    int            aw_hold = 0, ar_hold = 0;
    bit            aw_stab, ar_stab;
    logic [AW-1:0] aw_a0, ar_a0;
    logic [7:0]    aw_l0, ar_l0;
    logic [2:0]    aw_s0, ar_s0;

    always @(negedge ACLK) begin
        if (ARESET) begin
            aw_hold = 0;
            ar_hold = 0;
        end else begin
            if (AWVALID) begin
                if (aw_hold == 0) begin
                    aw_a0 = AWADDR; aw_l0 = AWLEN; aw_s0 = AWSIZE; aw_stab = 1'b1;
                end else if (AWADDR !== aw_a0 || AWLEN !== aw_l0 || AWSIZE !== aw_s0) begin
                    aw_stab = 1'b0;
                end
                aw_hold++;
                if (AWREADY) begin
                    observe(K_AW, 32'(aw_a0), addr_info(aw_l0, aw_s0, aw_hold, aw_stab), "aw");
                    aw_hold = 0;
                end
            end
            if (ARVALID) begin
                if (ar_hold == 0) begin
                    ar_a0 = ARADDR; ar_l0 = ARLEN; ar_s0 = ARSIZE; ar_stab = 1'b1;
                end else if (ARADDR !== ar_a0 || ARLEN !== ar_l0 || ARSIZE !== ar_s0) begin
                    ar_stab = 1'b0;
                end
                ar_hold++;
                if (ARREADY) begin
                    observe(K_AR, 32'(ar_a0), addr_info(ar_l0, ar_s0, ar_hold, ar_stab), "ar");
                    ar_hold = 0;
                end
            end
            if (WVALID && WREADY)   observe(K_W, WDATA, 32'(WLAST), "w_beat");
            if (rd_valid && rd_ready) observe(K_R, rd_data, 32'(rd_last), "rd_beat");
            if (done)               observe(K_D, 32'(done_resp), 32'd0, "done");
        end
    end

    task automatic idle_bus();
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    endtask

    task automatic issue(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
        int w = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
        @(negedge ACLK);
        while (!cmd_ready && w < 50) begin
            w++;
            @(negedge ACLK);
        end
        if (!cmd_ready) begin
            n_vec++; n_bad++;
            $display("FAIL cmd_accept: cmd_ready stuck at 0, required 1");
        end
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int aw_delay, input bit rnd, input logic [1:0] bresp,
                            input logic [1:0] exp_resp, input bit illegal, input logic [31:0] base);
        int aw_wait = 0;
        int wbeat = 0;
        int cyc;
        bit bdone = 1'b0;
        bit seen = 1'b0;
        if (!illegal) begin
            expq.push_back('{K_AW, 32'(addr), addr_info(len, size, aw_delay + 1, 1'b1)});
            for (int i = 0; i <= int'(len); i++)
                expq.push_back('{K_W, base + 32'(i), 32'(i == int'(len))});
        end
        expq.push_back('{K_D, 32'(exp_resp), 32'd0});
        issue(1'b1, addr, len, size);
        for (cyc = 0; cyc < 400; cyc++) begin
            AWREADY  = AWVALID && (aw_wait >= aw_delay);
            wd_valid = (wbeat <= int'(len)) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            wd_data  = base + 32'(wbeat);
            WREADY   = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            BVALID   = !illegal && (wbeat > int'(len)) && !bdone;
            BRESP    = bresp;
            @(negedge ACLK);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (AWVALID && !AWREADY) aw_wait++;
            if (wd_valid && wd_ready) wbeat++;
            if (BVALID && BREADY) bdone = 1'b1;
            @(posedge ACLK); #1;
        end
        if (!seen) begin
            n_vec++; n_bad++;
            $display("FAIL write_timeout: no done after %0d cycles, required done", cyc);
        end else if (illegal) begin
            chk("illegal_done_latency", 32'(cyc), 32'd0);
        end
        @(posedge ACLK); #1;
        idle_bus();
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int ar_delay, input bit rnd, input logic [15:0] resps,
                           input int rlast_beat, input int abort_beat,
                           input logic [1:0] exp_resp, input logic [31:0] base);
        int ar_wait = 0;
        int rbeat = 0;
        int nb;
        int cyc;
        bit started = 1'b0;
        bit seen = 1'b0;
        bit aborted = 1'b0;
        nb = (abort_beat >= 0) ? abort_beat : rlast_beat + 1;
        expq.push_back('{K_AR, 32'(addr), addr_info(len, size, ar_delay + 1, 1'b1)});
        for (int i = 0; i < nb; i++)
            expq.push_back('{K_R, base + 32'(i), 32'(i == rlast_beat)});
        if (abort_beat < 0) expq.push_back('{K_D, 32'(exp_resp), 32'd0});
        issue(1'b0, addr, len, size);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        for (cyc = 0; cyc < 400; cyc++) begin
            ARREADY  = ARVALID && (ar_wait >= ar_delay);
            RVALID   = started && (rbeat <= rlast_beat);
            RDATA    = base + 32'(rbeat);
            RRESP    = (rbeat < 8) ? resps[2*rbeat +: 2] : 2'b00;
            RLAST    = (rbeat == rlast_beat);
            rd_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (abort_beat >= 0 && started && rbeat == abort_beat) begin
                #2;
                ARESET = 1'b1;
                #1;
                chk("rst_rready",   32'(RREADY),   32'd0);
                chk("rst_rd_valid", 32'(rd_valid), 32'd0);
                chk("rst_done",     32'(done),     32'd0);
                chk("rst_valids",   {29'd0, ARVALID, AWVALID, WVALID}, 32'd0);
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                @(posedge ACLK); #1;
                ARESET  = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(negedge ACLK);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (ARVALID && ARREADY) started = 1'b1;
            else if (ARVALID) ar_wait++;
            if (RVALID && RREADY) rbeat++;
            @(posedge ACLK); #1;
        end
        if (!seen && !aborted) begin
            n_vec++; n_bad++;
            $display("FAIL read_timeout: no done after %0d cycles, required done", cyc);
        end
        @(posedge ACLK); #1;
        idle_bus();
    endtask

    initial begin
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        idle_bus();
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_valids", {26'd0, AWVALID, WVALID, ARVALID, rd_valid, BREADY, RREADY}, 32'd0);
        chk("reset_done", {28'd0, WLAST, done, done_resp}, 32'd0);
        chk("reset_addr", {AWADDR, AWLEN, 5'd0, AWSIZE}, 32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // 1: plain 4-beat write
        do_write(16'h0100, 8'd3, 3'd2, 0, 1'b0, 2'b00, 2'd0, 1'b0, 32'h1000_0000);
        // 2: single-beat read with ARREADY held off for 3 cycles
        do_read(16'h0200, 8'd0, 3'd2, 3, 1'b0, 16'h0000, 0, -1, 2'd0, 32'h2000_0000);
        // 3: 8-beat read, beat 5 reports SLVERR, rd_ready toggling
        do_read(16'h0300, 8'd7, 3'd2, 0, 1'b1, 16'h0800, 7, -1, 2'd2, 32'h3000_0000);
        // 3b: RLAST arrives on beat 1 of a 4-beat burst
        do_read(16'h0400, 8'd3, 3'd2, 1, 1'b0, 16'h0000, 1, -1, 2'd2, 32'h3100_0000);
        // 3c: EXOKAY on the first beat survives an OKAY second beat
        do_read(16'h0500, 8'd1, 3'd2, 0, 1'b0, 16'h0001, 1, -1, 2'd1, 32'h3200_0000);
        // 4: write crossing the 4 KB page
        do_write(16'h0FF8, 8'd3, 3'd2, 0, 1'b0, 2'b00, 2'd2, 1'b1, 32'h4000_0000);
        // 4b: write ending exactly on the page boundary is legal; slave answers DECERR
        do_write(16'h0FF0, 8'd3, 3'd2, 2, 1'b0, 2'b11, 2'd3, 1'b0, 32'h4100_0000);
        // 4c: beat size wider than the 32-bit bus
        do_write(16'h0100, 8'd0, 3'd3, 0, 1'b0, 2'b00, 2'd2, 1'b1, 32'h4200_0000);
        // 5: 16-beat write with random wd_valid and WREADY
        do_write(16'h0800, 8'd15, 3'd2, 1, 1'b1, 2'b00, 2'd0, 1'b0, 32'h5000_0000);
        // 6: reset during beat 2 of an 8-beat read, then a normal read
        do_read(16'h0600, 8'd7, 3'd2, 0, 1'b0, 16'h0000, 7, 2, 2'd0, 32'h6000_0000);
        repeat (3) @(posedge ACLK);
        #1;
        chk("abort_queue", 32'(expq.size()), 32'd0);
        do_read(16'h0700, 8'd1, 3'd2, 0, 1'b0, 16'h0000, 1, -1, 2'd0, 32'h6100_0000);

        repeat (5) @(posedge ACLK);
        #1;
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
